// File: rtl/egress_arbiter_pkg.sv
// Shared constants for the egress arbiter: subunit codes, FSM encoding, default widths.
package egress_arbiter_pkg;

    localparam int unsigned HDR_WIDTH_DEF     = 96;
    localparam int unsigned PAYLOAD_WIDTH_DEF = 32;
    localparam int unsigned DEST_WIDTH        = 3;
    localparam int unsigned NUM_SUBUNITS      = 3;

    localparam logic [2:0] DEST_CONFIG = 3'd1;
    localparam logic [2:0] DEST_MEMORY = 3'd2;
    localparam logic [2:0] DEST_IO     = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    // True for the three subunit codes that own a credit counter.
    function automatic logic dest_is_valid(input logic [2:0] d);
        return (d == DEST_CONFIG) || (d == DEST_MEMORY) || (d == DEST_IO);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any_c,
    output logic [$clog2(N)-1:0] idx_c
);

    localparam int unsigned IW = $clog2(N);

    int unsigned j;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        any_c = 1'b0;
        idx_c = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (32'(ptr) + 32'(k)) % N;
            if (!any_c && req[j]) begin
                any_c = 1'b1;
                idx_c = IW'(j);
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Credit-aware round-robin arbiter moving one header beat then one payload beat per grant.
module egress_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter int unsigned NUM_LINKS     = 4,
    parameter int unsigned HDR_WIDTH     = HDR_WIDTH_DEF,
    parameter int unsigned PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
    parameter int unsigned CREDITS_MAX   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_LINKS-1:0]               req_valid,
    input  logic [NUM_LINKS*HDR_WIDTH-1:0]     req_header,
    input  logic [NUM_LINKS*PAYLOAD_WIDTH-1:0] req_payload,
    input  logic [NUM_LINKS*3-1:0]             req_dest,
    output logic [NUM_LINKS-1:0]               req_ack,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [HDR_WIDTH-1:0]               out_data,
    output logic                               out_is_payload,
    output logic [2:0]                         out_dest,
    output logic [$clog2(NUM_LINKS)-1:0]       out_link,
    input  logic [2:0]                         credit_ret,
    output logic                               bad_dest_err
);

    localparam int unsigned LW = $clog2(NUM_LINKS);
    localparam int unsigned CW = $clog2(CREDITS_MAX + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDITS_MAX);

    logic [1:0]                         state_q, state_d;
    logic [LW-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [NUM_SUBUNITS-1:0][CW-1:0]    credit_q, credit_d;
    logic [PAYLOAD_WIDTH-1:0]           pay_q, pay_d;

    logic [NUM_LINKS-1:0]               req_ack_d;
    logic                               bad_dest_err_d;
    logic                               out_valid_d;
    logic [HDR_WIDTH-1:0]               out_data_d;
    logic                               out_is_payload_d;
    logic [2:0]                         out_dest_d;
    logic [LW-1:0]                      out_link_d;

    logic [NUM_LINKS-1:0]               eligible_c;
    logic                               win_any_c;
    logic [LW-1:0]                      win_idx_c;
    logic [2:0]                         win_dest_c;
    logic [NUM_SUBUNITS-1:0]            credit_take_c;

    // Invalid codes are always eligible so they can be dropped; valid codes need a credit.
    function automatic logic has_credit(input logic [2:0] d,
                                        input logic [NUM_SUBUNITS-1:0][CW-1:0] c);
        case (d)
            DEST_CONFIG: return c[0] != '0;
            DEST_MEMORY: return c[1] != '0;
            DEST_IO:     return c[2] != '0;
            default:     return 1'b1;
        endcase
    endfunction

    // Mask requests whose subunit is out of credits.
    always_comb begin
        eligible_c = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            eligible_c[i] = req_valid[i] && has_credit(req_dest[i*3 +: 3], credit_q);
        end
    end

    rr_arbiter #(
        .N (NUM_LINKS)
    ) u_rr_arbiter (
        .req   (eligible_c),
        .ptr   (rr_ptr_q),
        .any_c (win_any_c),
        .idx_c (win_idx_c)
    );

    assign win_dest_c = req_dest[32'(win_idx_c)*DEST_WIDTH +: DEST_WIDTH];

    // Next-state, capture, output and credit logic.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        credit_d         = credit_q;
        pay_d            = pay_q;
        req_ack_d        = '0;
        bad_dest_err_d   = 1'b0;
        out_valid_d      = out_valid;
        out_data_d       = out_data;
        out_is_payload_d = out_is_payload;
        out_dest_d       = out_dest;
        out_link_d       = out_link;
        credit_take_c    = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_any_c) begin
                    req_ack_d[win_idx_c] = 1'b1;
                    rr_ptr_d = (win_idx_c == LW'(NUM_LINKS - 1)) ? '0 : win_idx_c + 1'b1;
                    if (dest_is_valid(win_dest_c)) begin
                        state_d          = ST_HDR;
                        out_valid_d      = 1'b1;
                        out_is_payload_d = 1'b0;
                        out_data_d       = req_header[32'(win_idx_c)*HDR_WIDTH +: HDR_WIDTH];
                        pay_d            = req_payload[32'(win_idx_c)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                        out_dest_d       = win_dest_c;
                        out_link_d       = win_idx_c;
                        for (int d = 0; d < NUM_SUBUNITS; d++) begin
                            credit_take_c[d] = (win_dest_c == 3'(d + 1));
                        end
                    end else begin
                        bad_dest_err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (out_ready) begin
                    state_d          = ST_PAY;
                    out_is_payload_d = 1'b1;
                    out_data_d       = HDR_WIDTH'(pay_q);
                end
            end
            ST_PAY: begin
                if (out_ready) begin
                    state_d          = ST_IDLE;
                    out_valid_d      = 1'b0;
                    out_is_payload_d = 1'b0;
                    out_data_d       = '0;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                out_valid_d      = 1'b0;
                out_is_payload_d = 1'b0;
                out_data_d       = '0;
            end
        endcase

        // A return and a take in the same cycle cancel; returns saturate at full.
        for (int d = 0; d < NUM_SUBUNITS; d++) begin
            if (credit_ret[d] && !credit_take_c[d]) begin
                if (credit_q[d] != CREDIT_FULL) begin
                    credit_d[d] = credit_q[d] + 1'b1;
                end
            end else if (credit_take_c[d] && !credit_ret[d]) begin
                credit_d[d] = credit_q[d] - 1'b1;
            end
        end
    end

    // State and registered outputs; reset discards any in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            for (int d = 0; d < NUM_SUBUNITS; d++) begin
                credit_q[d] <= CREDIT_FULL;
            end
            pay_q          <= '0;
            req_ack        <= '0;
            bad_dest_err   <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_is_payload <= 1'b0;
            out_dest       <= '0;
            out_link       <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            credit_q       <= credit_d;
            pay_q          <= pay_d;
            req_ack        <= req_ack_d;
            bad_dest_err   <= bad_dest_err_d;
            out_valid      <= out_valid_d;
            out_data       <= out_data_d;
            out_is_payload <= out_is_payload_d;
            out_dest       <= out_dest_d;
            out_link       <= out_link_d;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed bench for egress_arbiter: ordering, credits, bad dest, stall, reset.
module tb_egress_arbiter;

    localparam int NL = 4;
    localparam int HW = 96;
    localparam int PW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NL-1:0]     req_valid;
    logic [NL*HW-1:0]  req_header;
    logic [NL*PW-1:0]  req_payload;
    logic [NL*3-1:0]   req_dest;
    logic [NL-1:0]     req_ack;
    logic              out_valid;
    logic              out_ready;
    logic [HW-1:0]     out_data;
    logic              out_is_payload;
    logic [2:0]        out_dest;
    logic [1:0]        out_link;
    logic [2:0]        credit_ret;
    logic              bad_dest_err;

    int n_checks = 0;
    int n_fail   = 0;

    egress_arbiter #(
        .NUM_LINKS     (NL),
        .HDR_WIDTH     (HW),
        .PAYLOAD_WIDTH (PW),
        .CREDITS_MAX   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_header     (req_header),
        .req_payload    (req_payload),
        .req_dest       (req_dest),
        .req_ack        (req_ack),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_is_payload (out_is_payload),
        .out_dest       (out_dest),
        .out_link       (out_link),
        .credit_ret     (credit_ret),
        .bad_dest_err   (bad_dest_err)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] hdr(input int i);
        return {24'hABCDEF, 8'(i), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic logic [127:0] payx(input int i);
        return 128'({24'h5A5A5A, 8'(i)});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int i, input logic [2:0] d);
        req_dest[i*3 +: 3] = d;
    endtask

    task automatic chk_hdr(input string tag, input int link, input logic [2:0] dest,
                           input logic [3:0] ack);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        chk({tag, "_isp"},   128'(out_is_payload), 128'(1'b0));
        chk({tag, "_data"},  128'(out_data), 128'(hdr(link)));
        chk({tag, "_link"},  128'(out_link), 128'(link));
        chk({tag, "_dest"},  128'(out_dest), 128'(dest));
        chk({tag, "_ack"},   128'(req_ack), 128'(ack));
    endtask

    task automatic chk_pay(input string tag, input int link);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        chk({tag, "_isp"},   128'(out_is_payload), 128'(1'b1));
        chk({tag, "_data"},  128'(out_data), payx(link));
        chk({tag, "_link"},  128'(out_link), 128'(link));
        chk({tag, "_ack"},   128'(req_ack), 128'(0));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_ack"},   128'(req_ack), 128'(0));
        chk({tag, "_bad"},   128'(bad_dest_err), 128'(1'b0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_data"},  128'(out_data), 128'(0));
        chk({tag, "_isp"},   128'(out_is_payload), 128'(0));
        chk({tag, "_dest"},  128'(out_dest), 128'(0));
        chk({tag, "_link"},  128'(out_link), 128'(0));
        chk({tag, "_ack"},   128'(req_ack), 128'(0));
        chk({tag, "_bad"},   128'(bad_dest_err), 128'(0));
    endtask

    initial begin
        req_valid  = '0;
        req_dest   = '0;
        out_ready  = 1'b1;
        credit_ret = '0;
        for (int i = 0; i < NL; i++) begin
            req_header[i*HW +: HW]  = hdr(i);
            req_payload[i*PW +: PW] = {24'h5A5A5A, 8'(i)};
        end

        // Asynchronous reset values
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("rst_async");
        step();
        step();

        // All links to memory: grants 0,1,2,3 with header then payload
        req_valid = 4'hF;
        for (int i = 0; i < NL; i++) set_dest(i, 3'd2);
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) begin
            step();
            chk_hdr($sformatf("rr_hdr%0d", i), i, 3'd2, 4'(1 << i));
            req_valid[i] = 1'b0;
            step();
            chk_pay($sformatf("rr_pay%0d", i), i);
            step();
            chk_quiet($sformatf("rr_idle%0d", i));
        end

        // Memory credits exhausted: config link served, memory link held
        req_valid = 4'b0011;
        set_dest(0, 3'd2);
        set_dest(1, 3'd1);
        step();
        chk_hdr("hol_cfg", 1, 3'd1, 4'b0010);
        req_valid[1] = 1'b0;
        step();
        step();
        step();
        chk_quiet("hol_held");
        credit_ret = 3'b010;
        step();
        chk_quiet("hol_ret_cycle");
        credit_ret = 3'b000;
        step();
        chk_hdr("hol_mem", 0, 3'd2, 4'b0001);
        req_valid[0] = 1'b0;
        step();
        step();

        // Invalid dest is acked and dropped
        req_valid = 4'b0100;
        set_dest(2, 3'd0);
        step();
        chk("bad_ack", 128'(req_ack), 128'(4'b0100));
        chk("bad_err", 128'(bad_dest_err), 128'(1'b1));
        chk("bad_valid", 128'(out_valid), 128'(1'b0));
        req_valid = '0;
        step();
        chk_quiet("bad_after");

        // Return and take on memory in the same cycle leaves the count at 1
        credit_ret = 3'b010;
        step();
        chk_quiet("same_ret0");
        req_valid = 4'b1000;
        set_dest(3, 3'd2);
        step();
        chk_hdr("same_grant", 3, 3'd2, 4'b1000);
        credit_ret = 3'b000;
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0001;
        set_dest(0, 3'd2);
        step();
        chk_hdr("same_use1", 0, 3'd2, 4'b0001);
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0001;
        step();
        chk_quiet("same_empty0");
        step();
        chk_quiet("same_empty1");
        req_valid = '0;

        // Config returns saturate at 4: exactly four further grants
        credit_ret = 3'b001;
        step();
        step();
        credit_ret = 3'b000;
        for (int k = 0; k < 4; k++) begin
            req_valid[1] = 1'b1;
            set_dest(1, 3'd1);
            step();
            chk_hdr($sformatf("sat_grant%0d", k), 1, 3'd1, 4'b0010);
            req_valid[1] = 1'b0;
            step();
            step();
        end
        req_valid[1] = 1'b1;
        step();
        chk_quiet("sat_denied0");
        step();
        chk_quiet("sat_denied1");
        req_valid = '0;

        // Backpressure on header and payload; a request that drops before IDLE is not taken
        out_ready = 1'b0;
        req_valid = 4'b0010;
        set_dest(1, 3'd3);
        set_dest(2, 3'd3);
        step();
        chk_hdr("stall_grant", 1, 3'd3, 4'b0010);
        req_valid[1] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 0) req_valid[2] = 1'b1;
            if (s == 2) req_valid[2] = 1'b0;
            step();
            chk_hdr($sformatf("stall_hdr%0d", s), 1, 3'd3, 4'b0000);
        end
        out_ready = 1'b1;
        step();
        chk_pay("stall_pay", 1);
        out_ready = 1'b0;
        step();
        chk_pay("stall_payhold0", 1);
        step();
        chk_pay("stall_payhold1", 1);
        out_ready = 1'b1;
        step();
        chk_quiet("stall_done");
        step();
        chk_quiet("stall_no_ghost");

        // Reset during payload beat
        req_valid = 4'b0100;
        set_dest(2, 3'd3);
        step();
        chk_hdr("rst_grant", 2, 3'd3, 4'b0100);
        req_valid = 4'b1001;
        set_dest(0, 3'd2);
        set_dest(3, 3'd2);
        step();
        chk_pay("rst_pay", 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("rst_mid");
        step();
        chk_reset_outs("rst_hold");
        rst_n = 1'b1;
        step();
        chk_hdr("rst_first", 0, 3'd2, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
